// File: rtl/cnt3_seq_ctrl_pkg.sv
// Shared types and constants for the 3-bit counter sequencer.
package cnt3_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic DIR_UP = 1'b0;
   localparam logic DIR_DN = 1'b1;

   localparam int unsigned W_DEF = 3;

endpackage

// File: rtl/cnt3_seq_ctrl_if.sv
// Control/status bundle between the sequencer and its controlling logic.
interface cnt3_seq_ctrl_if #(
   parameter int unsigned W = 3
);

   logic         start;
   logic         stop;
   logic         hold;
   logic         dir;
   logic [W-1:0] start_val;
   logic [W-1:0] end_val;
   logic [W-1:0] count;
   logic         cnt_en;
   logic         cnt_dir;
   logic         busy;
   logic         done;

   modport master (
      output start, stop, hold, dir, start_val, end_val,
      input  count, cnt_en, cnt_dir, busy, done
   );

   modport slave (
      input  start, stop, hold, dir, start_val, end_val,
      output count, cnt_en, cnt_dir, busy, done
   );

endinterface

// File: rtl/cnt3_seq_ctrl_updn.sv
// W-bit up/down counter with synchronous load and step enable; wraps modulo 2**W.
module cnt3_updn
   import cnt3_pkg::*;
#(
   parameter int unsigned W = W_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         en_i,
   input  logic         dir_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Load takes precedence over stepping.
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (en_i) begin
         count_d = (dir_i == DIR_DN) ? count_q - W'(1) : count_q + W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/cnt3_seq_ctrl.sv
// Run sequencer: loads the counter, steps it toward a latched end value and
// pulses done on arrival; supports hold (pause) and stop (abort).
module cnt3_seq_ctrl
   import cnt3_pkg::*;
#(
   parameter int unsigned W = W_DEF
) (
   input  logic          clk,
   input  logic          res,
   cnt3_seq_ctrl_if.slave bus
);

   state_t       state_q, state_d;
   logic [W-1:0] end_q, end_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;
   logic         cnt_en_q, cnt_en_d;
   logic         cnt_dir_q, cnt_dir_d;
   logic         load;
   logic         step;
   logic [W-1:0] count;
   logic [W-1:0] count_nxt;

   cnt3_updn #(.W(W)) u_cnt (
      .clk        (clk),
      .rst        (res),
      .load_i     (load),
      .load_val_i (bus.start_val),
      .en_i       (step),
      .dir_i      (cnt_dir_q),
      .count_o    (count)
   );

   assign count_nxt = (cnt_dir_q == DIR_DN) ? count - W'(1) : count + W'(1);

   always_comb begin
      state_d   = state_q;
      end_d     = end_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      cnt_en_d  = 1'b0;
      cnt_dir_d = cnt_dir_q;
      load      = 1'b0;
      step      = 1'b0;
      unique case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (bus.start) begin
               load      = 1'b1;
               cnt_dir_d = bus.dir;
               end_d     = bus.end_val;
               if (bus.start_val == bus.end_val) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = RUN;
                  busy_d  = 1'b1;
               end
            end
         end
         RUN: begin
            busy_d = 1'b1;
            // Stop outranks hold, which outranks stepping (and end detection).
            if (bus.stop) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end else if (!bus.hold) begin
               step     = 1'b1;
               cnt_en_d = 1'b1;
               if (count_nxt == end_q) begin
                  state_d = DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state_q   <= IDLE;
         end_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         cnt_en_q  <= 1'b0;
         cnt_dir_q <= DIR_UP;
      end else begin
         state_q   <= state_d;
         end_q     <= end_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         cnt_en_q  <= cnt_en_d;
         cnt_dir_q <= cnt_dir_d;
      end
   end

   assign bus.count   = count;
   assign bus.cnt_en  = cnt_en_q;
   assign bus.cnt_dir = cnt_dir_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;

endmodule
